// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared types and default constants for the PC / fetch stage.
//   pc_src_t      - next-PC select encoding driven by the branch comparator
//   fetch_state_t - fetch/execute sequencing states
//   DEFAULT_*     - default reset and trap vector addresses
// Optional feature macro used by the stage: PC_MISALIGN_TRAP_EN.
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_TARGET = 2'b01,
      PC_JALR   = 2'b10
   } pc_src_t;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      EXEC,
      TRAP
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/response bus.
//   imem_req   - fetch request (master -> slave)
//   imem_addr  - fetch address (master -> slave)
//   imem_ready - response valid, completes the request (slave -> master)
//   imem_rdata - fetched instruction word (slave -> master)
interface pc_fetch_unit_if #(
   parameter int unsigned N = 32
);
   logic         imem_req;
   logic [N-1:0] imem_addr;
   logic         imem_ready;
   logic [31:0]  imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/next_pc_gen.sv
// next_pc_gen: combinational next-PC selection.
//   pc         in  current PC
//   imm_ext    in  sign-extended immediate
//   jalr_base  in  rs1 value for JALR
//   pc_src     in  select: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1, 11 as 00
//   next_pc    out selected next PC (all adds wrap modulo 2^N)
//   misaligned out next_pc[1:0] != 0
module next_pc_gen
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] pc,
   input  logic [N-1:0] imm_ext,
   input  logic [N-1:0] jalr_base,
   input  logic [1:0]   pc_src,
   output logic [N-1:0] next_pc,
   output logic         misaligned
);

   logic [N-1:0] jalr_sum;

   assign jalr_sum = jalr_base + imm_ext;

   always_comb begin
      next_pc = pc + N'(4);
      case (pc_src_t'(pc_src))
         PC_TARGET: next_pc = pc + imm_ext;
         PC_JALR:   next_pc = {jalr_sum[N-1:1], 1'b0};
         default:   next_pc = pc + N'(4);
      endcase
   end

   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC and instruction-fetch stage.
// Sequence: BOOT (one cycle) -> FETCH (request until imem_ready) -> EXEC (until retire).
// Optional macro PC_MISALIGN_TRAP_EN: a misaligned next PC on retire traps to TRAP_VEC.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   PCSrc           - next-PC select from the comparator
//   ImmExt          - sign-extended immediate
//   JalrBase        - rs1 value for JALR
//   retire          - current instruction completes (sampled in EXEC only)
//   imem            - instruction-memory bus (master side)
//   instr           - buffered instruction
//   instr_valid     - instr holds the instruction at PC
//   PC, PCPlus4     - current PC and its link value
//   trap, trap_addr - one-cycle misaligned-target pulse and faulting address
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned N        = 32,
   parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
   parameter logic [N-1:0] TRAP_VEC = N'(DEFAULT_TRAP_VEC)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           PCSrc,
   input  logic [N-1:0]         ImmExt,
   input  logic [N-1:0]         JalrBase,
   input  logic                 retire,
   pc_fetch_unit_if.master      imem,
   output logic [31:0]          instr,
   output logic                 instr_valid,
   output logic [N-1:0]         PC,
   output logic [N-1:0]         PCPlus4,
   output logic                 trap,
   output logic [N-1:0]         trap_addr
);

   fetch_state_t state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [N-1:0] next_pc;
   logic         misaligned;

   next_pc_gen #(
      .N (N)
   ) u_next_pc_gen (
      .pc         (pc_q),
      .imm_ext    (ImmExt),
      .jalr_base  (JalrBase),
      .pc_src     (PCSrc),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

`ifdef PC_MISALIGN_TRAP_EN
   logic [N-1:0] trap_addr_q, trap_addr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trap_addr_q <= '0;
      else        trap_addr_q <= trap_addr_d;
   end

   assign trap      = (state_q == TRAP);
   assign trap_addr = trap_addr_q;
`else
   logic unused_cfg;

   assign unused_cfg = misaligned ^ (|TRAP_VEC);
   assign trap       = 1'b0;
   assign trap_addr  = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
`ifdef PC_MISALIGN_TRAP_EN
      trap_addr_d = trap_addr_q;
`endif
      case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (imem.imem_ready) begin
               instr_d = imem.imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (retire) begin
`ifdef PC_MISALIGN_TRAP_EN
               // A misaligned target never reaches PC; it is reported instead.
               if (misaligned) begin
                  trap_addr_d = next_pc;
                  state_d     = TRAP;
               end else begin
                  pc_d    = next_pc;
                  state_d = FETCH;
               end
`else
               pc_d    = next_pc;
               state_d = FETCH;
`endif
            end
         end
`ifdef PC_MISALIGN_TRAP_EN
         TRAP: begin
            pc_d    = TRAP_VEC;
            state_d = FETCH;
         end
`endif
         default: state_d = BOOT;
      endcase
   end

   assign imem.imem_req  = (state_q == FETCH);
   assign imem.imem_addr = pc_q;
   assign instr_valid    = (state_q == EXEC);
   assign instr          = instr_q;
   assign PC             = pc_q;
   assign PCPlus4        = pc_q + N'(4);

endmodule
